// File: rtl/gpio_irq_port.sv
// GPIO port with synchronized inputs, per-pin edge interrupts and a
// two-cycle register access handshake (sel held until a one-cycle ack).
module gpio_irq_port #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sel,
   input  logic             we,
   input  logic [2:0]       addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             ack,
   input  logic [WIDTH-1:0] gpio_i,
   output logic [WIDTH-1:0] gpio_o,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             irq
);

   localparam logic [2:0] ADDR_IN       = 3'd0;
   localparam logic [2:0] ADDR_OUT      = 3'd1;
   localparam logic [2:0] ADDR_DIR      = 3'd2;
   localparam logic [2:0] ADDR_IRQ_EN   = 3'd3;
   localparam logic [2:0] ADDR_IRQ_EDGE = 3'd4;
   localparam logic [2:0] ADDR_IRQ_PEND = 3'd5;
   localparam logic [2:0] ADDR_TOGGLE   = 3'd6;

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] dir_q, dir_d;
   logic [WIDTH-1:0] en_q, en_d;
   logic [WIDTH-1:0] edge_q, edge_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];

   logic [WIDTH-1:0] sync_in;
   logic [WIDTH-1:0] rise, fall, pend_set, pend_clr;
   logic [WIDTH-1:0] rd_mux;

   // Input synchronizer plus the previous-value register used for edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         prev_q <= '0;
      end else begin
         sync_q[0] <= gpio_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign sync_in  = sync_q[SYNC_STAGES-1];
   assign rise     = sync_in & ~prev_q;
   assign fall     = ~sync_in & prev_q;
   assign pend_set = (rise & edge_q) | (fall & ~edge_q);

   always_comb begin
      rd_mux = '0;
      case (addr)
         ADDR_IN:       rd_mux = sync_in;
         ADDR_OUT:      rd_mux = out_q;
         ADDR_DIR:      rd_mux = dir_q;
         ADDR_IRQ_EN:   rd_mux = en_q;
         ADDR_IRQ_EDGE: rd_mux = edge_q;
         ADDR_IRQ_PEND: rd_mux = pend_q;
         default:       rd_mux = '0;
      endcase
   end

   // Access FSM: the register side effect happens on the IDLE->ACK edge.
   always_comb begin
      state_d  = state_q;
      out_d    = out_q;
      dir_d    = dir_q;
      en_d     = en_q;
      edge_d   = edge_q;
      rdata_d  = rdata_q;
      pend_clr = '0;
      case (state_q)
         IDLE: begin
            if (sel) begin
               state_d = ACK;
               if (we) begin
                  case (addr)
                     ADDR_OUT:      out_d    = wdata;
                     ADDR_DIR:      dir_d    = wdata;
                     ADDR_IRQ_EN:   en_d     = wdata;
                     ADDR_IRQ_EDGE: edge_d   = wdata;
                     ADDR_IRQ_PEND: pend_clr = wdata;
                     ADDR_TOGGLE:   out_d    = out_q ^ wdata;
                     default:       out_d    = out_q;
                  endcase
               end else begin
                  rdata_d = rd_mux;
               end
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // A new edge beats a same-cycle write-1-to-clear of that bit.
   assign pend_d = (pend_q & ~pend_clr) | pend_set;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         out_q   <= '0;
         dir_q   <= '0;
         en_q    <= '0;
         edge_q  <= '0;
         pend_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         dir_q   <= dir_d;
         en_q    <= en_d;
         edge_q  <= edge_d;
         pend_q  <= pend_d;
         rdata_q <= rdata_d;
      end
   end

   assign ack     = (state_q == ACK);
   assign rdata   = rdata_q;
   assign gpio_o  = out_q;
   assign gpio_oe = dir_q;
   assign irq     = |(pend_q & en_q);

endmodule

// File: tb/tb_gpio_irq_port.sv
// Self-checking bench for gpio_irq_port: directed scenarios plus a randomized
// run against a delay-line reference model of the pins and register map.
module tb_gpio_irq_port;
  localparam int W = 8;
  localparam int S = 2;

  // clock / reset
  logic         clk;
  logic         rst;
  logic         sel;
  logic         we;
  logic [2:0]   addr;
  logic [W-1:0] wdata;
  logic [W-1:0] rdata;
  logic         ack;
  logic [W-1:0] gpio_i;
  logic [W-1:0] gpio_o;
  logic [W-1:0] gpio_oe;
  logic         irq;

  int n_checks = 0;
  int n_fail   = 0;

  gpio_irq_port #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk     (clk),
    .rst     (rst),
    .sel     (sel),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .ack     (ack),
    .gpio_i  (gpio_i),
    .gpio_o  (gpio_o),
    .gpio_oe (gpio_oe),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: registers, pin sample history, expected read queue
  logic [W-1:0] m_out, m_dir, m_en, m_edge, m_pend, m_rdata;
  logic         m_busy;
  logic [W-1:0] pin_q[$];
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return pin_q[1];
      3'd1: return m_out;
      3'd2: return m_dir;
      3'd3: return m_en;
      3'd4: return m_edge;
      3'd5: return m_pend;
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    m_out = '0; m_dir = '0; m_en = '0; m_edge = '0; m_pend = '0; m_rdata = '0;
    m_busy = 1'b0;
    pin_q.delete();
    exp_q.delete();
    for (int i = 0; i < S + 1; i++) pin_q.push_back('0);
  endtask

  // One clock: fold the inputs present at the edge into the model, then
  // advance the DUT and return 1 time unit after the edge.
  task automatic tick();
    logic [W-1:0] prv, cur, set_v, new_pend, rd;
    if (rst) begin
      prv = pin_q[0];
      cur = pin_q[1];
      set_v = ((cur & ~prv) & m_edge) | ((~cur & prv) & ~m_edge);
      new_pend = m_pend | set_v;
      if (!m_busy && sel) begin
        if (!we) begin
          rd = model_read(addr);
          m_rdata = rd;
          exp_q.push_back(rd);
        end else begin
          case (addr)
            3'd1: m_out = wdata;
            3'd2: m_dir = wdata;
            3'd3: m_en = wdata;
            3'd4: m_edge = wdata;
            3'd5: new_pend = (m_pend & ~wdata) | set_v;
            3'd6: m_out = m_out ^ wdata;
            default: ;
          endcase
        end
        m_busy = 1'b1;
      end else begin
        m_busy = 1'b0;
      end
      m_pend = new_pend;
      void'(pin_q.pop_front());
      pin_q.push_back(gpio_i);
    end
    @(posedge clk);
    #1;
  endtask

  // driver: one complete access, sel dropped after the accepting edge
  task automatic access(input logic w, input logic [2:0] a, input logic [W-1:0] d,
                        output logic ack1, output logic ack2, output logic [W-1:0] rd);
    sel = 1'b1; we = w; addr = a; wdata = d;
    tick();
    ack1 = ack;
    rd = rdata;
    sel = 1'b0; we = 1'b0;
    tick();
    ack2 = ack;
  endtask

  task automatic test_reset();
    logic a1, a2;
    logic [W-1:0] rd;
    rst = 1'b0; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0; gpio_i = '0;
    model_reset();
    repeat (3) tick();
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", ack); end
    n_checks++; if (rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    n_checks++; if (gpio_oe !== '0) begin n_fail++; $display("FAIL reset_oe: got %h expected 00", gpio_oe); end
    n_checks++; if (gpio_o !== '0) begin n_fail++; $display("FAIL reset_out: got %h expected 00", gpio_o); end
    rst = 1'b1;
    for (int a = 0; a < 8; a++) begin
      access(1'b0, a[2:0], '0, a1, a2, rd);
      n_checks++;
      if (rd !== '0 || a1 !== 1'b1) begin
        n_fail++; $display("FAIL reset_read%0d: got %h ack %b expected 00 ack 1", a, rd, a1);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_out_dir();
    logic a1, a2;
    logic [W-1:0] rd;
    access(1'b1, 3'd1, 8'hA5, a1, a2, rd);
    access(1'b1, 3'd2, 8'h0F, a1, a2, rd);
    n_checks++; if (gpio_o !== 8'hA5) begin n_fail++; $display("FAIL gpio_o: got %h expected a5", gpio_o); end
    n_checks++; if (gpio_oe !== 8'h0F) begin n_fail++; $display("FAIL gpio_oe: got %h expected 0f", gpio_oe); end
    access(1'b0, 3'd1, '0, a1, a2, rd);
    n_checks++; if (rd !== 8'hA5) begin n_fail++; $display("FAIL read_out: got %h expected a5", rd); end
    n_checks++; if (a1 !== 1'b1 || a2 !== 1'b0) begin n_fail++; $display("FAIL ack_pulse: got %b%b expected 10", a1, a2); end
    exp_q.delete();
  endtask

  task automatic test_rise_irq();
    logic a1, a2;
    logic [W-1:0] rd;
    int lat;
    gpio_i = '0;
    access(1'b1, 3'd3, 8'h01, a1, a2, rd);
    access(1'b1, 3'd4, 8'h01, a1, a2, rd);
    repeat (4) tick();
    access(1'b1, 3'd5, 8'hFF, a1, a2, rd);
    gpio_i = 8'h01;
    lat = 0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      tick();
      if (irq === 1'b1) lat = c;
    end
    n_checks++; if (lat != S + 1) begin n_fail++; $display("FAIL irq_latency: got %0d expected %0d", lat, S + 1); end
    access(1'b0, 3'd5, '0, a1, a2, rd);
    n_checks++; if (rd !== 8'h01) begin n_fail++; $display("FAIL pend_rise: got %h expected 01", rd); end
    access(1'b1, 3'd5, 8'h01, a1, a2, rd);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_w1c: got %b expected 0", irq); end
    exp_q.delete();
  endtask

  task automatic test_fall_pending();
    logic a1, a2;
    logic [W-1:0] rd;
    access(1'b1, 3'd3, 8'h00, a1, a2, rd);
    access(1'b1, 3'd4, 8'h00, a1, a2, rd);
    gpio_i = 8'h08;
    repeat (4) tick();
    access(1'b1, 3'd5, 8'hFF, a1, a2, rd);
    gpio_i = 8'h00;
    repeat (4) tick();
    access(1'b0, 3'd5, '0, a1, a2, rd);
    n_checks++; if (rd !== 8'h08) begin n_fail++; $display("FAIL pend_fall: got %h expected 08", rd); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b expected 0", irq); end
    access(1'b1, 3'd3, 8'h08, a1, a2, rd);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_enable: got %b expected 1", irq); end
    exp_q.delete();
  endtask

  task automatic test_set_wins();
    logic a1, a2;
    logic [W-1:0] rd;
    access(1'b1, 3'd3, 8'h00, a1, a2, rd);
    access(1'b1, 3'd4, 8'h04, a1, a2, rd);
    access(1'b1, 3'd5, 8'hFF, a1, a2, rd);
    repeat (4) tick();
    gpio_i = 8'h04;
    tick();
    tick();
    access(1'b1, 3'd5, 8'h04, a1, a2, rd);
    access(1'b0, 3'd5, '0, a1, a2, rd);
    n_checks++; if (rd !== 8'h04) begin n_fail++; $display("FAIL set_wins: got %h expected 04", rd); end
    access(1'b1, 3'd5, 8'h04, a1, a2, rd);
    access(1'b0, 3'd5, '0, a1, a2, rd);
    n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL w1c_later: got %h expected 00", rd); end
    exp_q.delete();
  endtask

  task automatic test_toggle();
    logic a1, a2;
    logic [W-1:0] rd;
    access(1'b1, 3'd1, 8'hF0, a1, a2, rd);
    access(1'b1, 3'd6, 8'hFF, a1, a2, rd);
    access(1'b0, 3'd1, '0, a1, a2, rd);
    n_checks++; if (rd !== 8'h0F) begin n_fail++; $display("FAIL toggle: got %h expected 0f", rd); end
    access(1'b0, 3'd6, '0, a1, a2, rd);
    n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL read6: got %h expected 00", rd); end
    access(1'b0, 3'd7, '0, a1, a2, rd);
    n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL read7: got %h expected 00", rd); end
    access(1'b1, 3'd0, 8'hFF, a1, a2, rd);
    access(1'b1, 3'd7, 8'hFF, a1, a2, rd);
    access(1'b0, 3'd1, '0, a1, a2, rd);
    n_checks++; if (rd !== 8'h0F) begin n_fail++; $display("FAIL write07_noeffect: got %h expected 0f", rd); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [3:0] seen;
    sel = 1'b1; we = 1'b0; addr = 3'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen[3-i] = ack;
    end
    sel = 1'b0;
    tick();
    n_checks++; if (seen !== 4'b1010) begin n_fail++; $display("FAIL back_to_back_ack: got %b expected 1010", seen); end
    n_checks++; if (rdata !== 8'h0F) begin n_fail++; $display("FAIL back_to_back_rdata: got %h expected 0f", rdata); end
    exp_q.delete();
  endtask

  task automatic test_random();
    logic a1, a2, w;
    logic [2:0] a;
    logic [W-1:0] rd, exp;
    exp_q.delete();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 2) == 0) gpio_i = W'($urandom);
      w = 1'($urandom_range(0, 1));
      a = 3'($urandom_range(0, 7));
      access(w, a, W'($urandom), a1, a2, rd);
      n_checks++; if (a1 !== 1'b1 || a2 !== 1'b0) begin n_fail++; $display("FAIL rnd_ack[%0d]: got %b%b expected 10", n, a1, a2); end
      if (!w) begin
        exp = exp_q.pop_front();
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL rnd_read[%0d] addr %0d: got %h expected %h", n, a, rd, exp); end
      end else begin
        n_checks++; if (rdata !== m_rdata) begin n_fail++; $display("FAIL rnd_rdata_hold[%0d]: got %h expected %h", n, rdata, m_rdata); end
      end
      n_checks++;
      if (gpio_o !== m_out || gpio_oe !== m_dir || irq !== |(m_pend & m_en)) begin
        n_fail++;
        $display("FAIL rnd_pins[%0d]: got o=%h oe=%h irq=%b expected o=%h oe=%h irq=%b",
                 n, gpio_o, gpio_oe, irq, m_out, m_dir, |(m_pend & m_en));
      end
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic test_reset_mid_access();
    logic a1, a2;
    logic [W-1:0] rd;
    gpio_i = '0;
    sel = 1'b1; we = 1'b1; addr = 3'd2; wdata = 8'hFF;
    tick();
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL mid_ack_before: got %b expected 1", ack); end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL mid_ack_async: got %b expected 0", ack); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL mid_ack_held[%0d]: got %b expected 0", i, ack); end
    end
    rst = 1'b1;
    sel = 1'b0; we = 1'b0;
    for (int a = 0; a < 6; a++) begin
      access(1'b0, a[2:0], '0, a1, a2, rd);
      n_checks++;
      if (rd !== '0 || a1 !== 1'b1) begin
        n_fail++; $display("FAIL mid_read%0d: got %h ack %b expected 00 ack 1", a, rd, a1);
      end
    end
    n_checks++; if (gpio_oe !== '0 || irq !== 1'b0) begin n_fail++; $display("FAIL mid_pins: got oe=%h irq=%b expected 00 0", gpio_oe, irq); end
  endtask

  initial begin
    test_reset();
    test_out_dir();
    test_rise_irq();
    test_fall_pending();
    test_set_wins();
    test_toggle();
    test_back_to_back();
    test_random();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
